// File: rtl/c1541_gcr_sector_encoder_if.sv
// Sector request, sector-cache read port and track-buffer write port of the GCR sector encoder.
interface c1541_gcr_sector_encoder_if;
    logic        start;
    logic [5:0]  track;
    logic [4:0]  sector;
    logic [7:0]  id1;
    logic [7:0]  id2;
    logic [12:0] base_addr;
    logic [7:0]  data_addr;
    logic [7:0]  data_in;
    logic [12:0] out_addr;
    logic [7:0]  out_data;
    logic        out_we;
    logic        busy;
    logic        done;
    logic [12:0] out_len;

    // Track builder / sector cache side
    modport master (
        output start, track, sector, id1, id2, base_addr, data_in,
        input  data_addr, out_addr, out_data, out_we, busy, done, out_len
    );

    // Encoder side
    modport slave (
        input  start, track, sector, id1, id2, base_addr, data_in,
        output data_addr, out_addr, out_data, out_we, busy, done, out_len
    );
endinterface

// File: rtl/c1541_gcr_sector_encoder.sv
// Builds one 1541 sector as raw GCR bytes: sync, header, gap, sync, data, gap.
module c1541_gcr_sector_encoder #(
    parameter int unsigned GAP1_LEN = 9,
    parameter int unsigned GAP2_LEN = 8,
    parameter int unsigned SYNC_LEN = 5
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ce,
    c1541_gcr_sector_encoder_if.slave bus
);
    localparam int unsigned CW       = 9;
    localparam int unsigned AW       = 13;
    localparam int unsigned HDR_RAW  = 8;
    localparam int unsigned DATA_RAW = 260;

    typedef enum logic [2:0] {
        IDLE, SYNC_H, HDR, GAP1, SYNC_D, DATA, GAP2, FIN
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;          // raw byte index within the current field
    logic           emit_q, emit_d;        // GCR fields: 0 = collecting raw bytes, 1 = emitting
    logic [2:0]     sub_q, sub_d;          // output byte index within a 5-byte group
    logic [23:0]    grp_q, grp_d;          // first three raw bytes of the current group
    logic [39:0]    shift_q, shift_d;      // encoded group, shifted out MSB first
    logic [7:0]     dchk_q, dchk_d;
    logic [5:0]     track_q, track_d;
    logic [4:0]     sector_q, sector_d;
    logic [7:0]     id1_q, id1_d;
    logic [7:0]     id2_q, id2_d;
    logic [7:0]     data_addr_q, data_addr_d;
    logic [AW-1:0]  out_addr_q, out_addr_d;
    logic [7:0]     out_data_q, out_data_d;
    logic           out_we_q, out_we_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [AW-1:0]  out_len_q, out_len_d;
    logic           pend_q, pend_d;        // a byte was written; bump addr/len on next ce

    logic [7:0]     hchk_c;
    logic [7:0]     raw_byte_c;
    logic [CW-1:0]  raw_last_c;
    logic [CW-1:0]  gcr_total_c;

    // Nibble to 5-bit GCR code
    function automatic logic [4:0] gcr5(input logic [3:0] n);
        logic [4:0] c;
        case (n)
            4'h0: c = 5'b01010;
            4'h1: c = 5'b01011;
            4'h2: c = 5'b10010;
            4'h3: c = 5'b10011;
            4'h4: c = 5'b01110;
            4'h5: c = 5'b01111;
            4'h6: c = 5'b10110;
            4'h7: c = 5'b10111;
            4'h8: c = 5'b01001;
            4'h9: c = 5'b11001;
            4'hA: c = 5'b11010;
            4'hB: c = 5'b11011;
            4'hC: c = 5'b01101;
            4'hD: c = 5'b11101;
            4'hE: c = 5'b11110;
            default: c = 5'b10101;
        endcase
        return c;
    endfunction

    // Four raw bytes to 40 GCR bits, high nibble first
    function automatic logic [39:0] gcr40(input logic [31:0] w);
        logic [39:0] g;
        g = '0;
        for (int i = 0; i < 8; i++) begin
            g[5*i +: 5] = gcr5(w[4*i +: 4]);
        end
        return g;
    endfunction

    assign hchk_c = 8'({3'b000, sector_q}) ^ 8'({2'b00, track_q}) ^ id2_q ^ id1_q;
    assign gcr_total_c = (state_q == HDR) ? CW'(HDR_RAW) : CW'(DATA_RAW);

    // Last index of the raw (unencoded) fill fields
    always_comb begin
        raw_last_c = '0;
        case (state_q)
            SYNC_H, SYNC_D: raw_last_c = CW'(SYNC_LEN - 1);
            GAP1:           raw_last_c = CW'(GAP1_LEN - 1);
            GAP2:           raw_last_c = CW'(GAP2_LEN - 1);
            default:        raw_last_c = '0;
        endcase
    end

    // Raw byte feeding the GCR packer for header and data blocks
    always_comb begin
        raw_byte_c = 8'h00;
        if (state_q == HDR) begin
            case (cnt_q[2:0])
                3'd0:    raw_byte_c = 8'h08;
                3'd1:    raw_byte_c = hchk_c;
                3'd2:    raw_byte_c = 8'({3'b000, sector_q});
                3'd3:    raw_byte_c = 8'({2'b00, track_q});
                3'd4:    raw_byte_c = id2_q;
                3'd5:    raw_byte_c = id1_q;
                default: raw_byte_c = 8'h0F;
            endcase
        end else if (cnt_q == CW'(0)) begin
            raw_byte_c = 8'h07;
        end else if (cnt_q <= CW'(256)) begin
            raw_byte_c = bus.data_in;
        end else if (cnt_q == CW'(257)) begin
            raw_byte_c = dchk_q;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (ce) begin
            case (state_q)
                IDLE:   if (bus.start) state_d = SYNC_H;
                SYNC_H: if (cnt_q == raw_last_c) state_d = HDR;
                HDR:    if (emit_q && sub_q == 3'd4 && cnt_q == gcr_total_c) state_d = GAP1;
                GAP1:   if (cnt_q == raw_last_c) state_d = SYNC_D;
                SYNC_D: if (cnt_q == raw_last_c) state_d = DATA;
                DATA:   if (emit_q && sub_q == 3'd4 && cnt_q == gcr_total_c) state_d = GAP2;
                GAP2:   if (cnt_q == raw_last_c) state_d = FIN;
                FIN:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath and output next values
    always_comb begin
        cnt_d       = cnt_q;
        emit_d      = emit_q;
        sub_d       = sub_q;
        grp_d       = grp_q;
        shift_d     = shift_q;
        dchk_d      = dchk_q;
        track_d     = track_q;
        sector_d    = sector_q;
        id1_d       = id1_q;
        id2_d       = id2_q;
        data_addr_d = data_addr_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        out_len_d   = out_len_q;
        busy_d      = busy_q;
        pend_d      = pend_q;
        out_we_d    = 1'b0;
        done_d      = 1'b0;
        if (ce) begin
            out_addr_d = pend_q ? AW'(out_addr_q + AW'(1)) : out_addr_q;
            out_len_d  = pend_q ? AW'(out_len_q + AW'(1)) : out_len_q;
            pend_d     = 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        track_d     = bus.track;
                        sector_d    = bus.sector;
                        id1_d       = bus.id1;
                        id2_d       = bus.id2;
                        out_addr_d  = bus.base_addr;
                        out_len_d   = '0;
                        busy_d      = 1'b1;
                        dchk_d      = 8'h00;
                        cnt_d       = '0;
                        emit_d      = 1'b0;
                        sub_d       = 3'd0;
                        data_addr_d = 8'h00;
                    end
                end
                SYNC_H, SYNC_D, GAP1, GAP2: begin
                    out_data_d = (state_q == SYNC_H || state_q == SYNC_D) ? 8'hFF : 8'h55;
                    out_we_d   = 1'b1;
                    pend_d     = 1'b1;
                    cnt_d      = (cnt_q == raw_last_c) ? '0 : CW'(cnt_q + CW'(1));
                end
                HDR, DATA: begin
                    if (!emit_q) begin
                        grp_d = {grp_q[15:0], raw_byte_c};
                        cnt_d = CW'(cnt_q + CW'(1));
                        if (state_q == DATA) begin
                            if (cnt_q >= CW'(1) && cnt_q <= CW'(256)) dchk_d = dchk_q ^ bus.data_in;
                            if (cnt_q >= CW'(1) && cnt_q <= CW'(255)) data_addr_d = 8'(cnt_q);
                        end
                        if (cnt_q[1:0] == 2'd3) begin
                            shift_d = gcr40({grp_q, raw_byte_c});
                            emit_d  = 1'b1;
                            sub_d   = 3'd0;
                        end
                    end else begin
                        out_data_d = shift_q[39:32];
                        out_we_d   = 1'b1;
                        pend_d     = 1'b1;
                        shift_d    = {shift_q[31:0], 8'h00};
                        if (sub_q == 3'd4) begin
                            emit_d = 1'b0;
                            sub_d  = 3'd0;
                            if (cnt_q == gcr_total_c) cnt_d = '0;
                        end else begin
                            sub_d = 3'(sub_q + 3'd1);
                        end
                    end
                end
                FIN: begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            emit_q      <= 1'b0;
            sub_q       <= 3'd0;
            grp_q       <= '0;
            shift_q     <= '0;
            dchk_q      <= 8'h00;
            track_q     <= '0;
            sector_q    <= '0;
            id1_q       <= 8'h00;
            id2_q       <= 8'h00;
            data_addr_q <= 8'h00;
            out_addr_q  <= '0;
            out_data_q  <= 8'h00;
            out_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_len_q   <= '0;
            pend_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            emit_q      <= emit_d;
            sub_q       <= sub_d;
            grp_q       <= grp_d;
            shift_q     <= shift_d;
            dchk_q      <= dchk_d;
            track_q     <= track_d;
            sector_q    <= sector_d;
            id1_q       <= id1_d;
            id2_q       <= id2_d;
            data_addr_q <= data_addr_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            out_we_q    <= out_we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_len_q   <= out_len_d;
            pend_q      <= pend_d;
        end
    end

    assign bus.data_addr = data_addr_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_we    = out_we_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.out_len   = out_len_q;

endmodule

// File: tb/tb_c1541_gcr_sector_encoder.sv
// Self-checking bench: random sectors against a bit-stream reference model of the 1541 format.
module tb_c1541_gcr_sector_encoder;
    localparam int unsigned SYNC_LEN = 5;
    localparam int unsigned GAP1_LEN = 9;
    localparam int unsigned GAP2_LEN = 8;
    localparam int unsigned HDR_OFF  = SYNC_LEN;
    localparam int unsigned DATA_OFF = SYNC_LEN + 10 + GAP1_LEN + SYNC_LEN;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    logic ce      = 1'b0;

    c1541_gcr_sector_encoder_if bus();

    c1541_gcr_sector_encoder #(
        .GAP1_LEN(GAP1_LEN),
        .GAP2_LEN(GAP2_LEN),
        .SYNC_LEN(SYNC_LEN)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .ce(ce),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Sector cache: byte valid in the clock after the address changes
    logic [7:0] mem   [256];
    logic [7:0] mem_b [256];
    assign bus.data_in = mem[bus.data_addr];

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int ce_viol = 0;
    logic ce_edge = 1'b0;
    logic [7:0]  cap_data[$];
    logic [12:0] cap_addr[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  raw_q[$];
    logic [7:0]  dec_q[$];
    logic [7:0]  ref_q[$];
    int dec_bad;

    // Capture every write strobe and done pulse away from the active edge
    always @(posedge clk) ce_edge <= ce;
    always @(negedge clk) begin
        if (bus.out_we === 1'b1) begin
            cap_data.push_back(bus.out_data);
            cap_addr.push_back(bus.out_addr);
            if (!ce_edge) ce_viol++;
        end
        if (bus.done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] gcr(input logic [3:0] n);
        logic [4:0] t [16];
        t = '{5'b01010, 5'b01011, 5'b10010, 5'b10011, 5'b01110, 5'b01111, 5'b10110, 5'b10111,
              5'b01001, 5'b11001, 5'b11010, 5'b11011, 5'b01101, 5'b11101, 5'b11110, 5'b10101};
        return t[n];
    endfunction

    function automatic logic [4:0] ungcr(input logic [4:0] c);
        for (int n = 0; n < 16; n++) begin
            if (gcr(4'(n)) == c) return {1'b0, 4'(n)};
        end
        return 5'h10;
    endfunction

    // Append raw_q to exp_q as a GCR bit stream packed 8 bits per byte
    task automatic gcr_pack();
        bit bits[$];
        logic [4:0] c;
        logic [7:0] v;
        foreach (raw_q[i]) begin
            v = raw_q[i];
            c = gcr(v[7:4]);
            for (int b = 4; b >= 0; b--) bits.push_back(c[b]);
            c = gcr(v[3:0]);
            for (int b = 4; b >= 0; b--) bits.push_back(c[b]);
        end
        for (int k = 0; k < bits.size(); k += 8) begin
            v = 8'h00;
            for (int b = 0; b < 8; b++) v = {v[6:0], bits[k+b]};
            exp_q.push_back(v);
        end
    endtask

    // Decode nraw raw bytes from captured bytes starting at off
    task automatic gcr_unpack(input int off, input int nraw);
        bit bits[$];
        logic [4:0] c, nh, nl;
        logic [7:0] v;
        dec_q.delete();
        dec_bad = 0;
        c = '0;
        for (int k = off; k < off + nraw * 10 / 8; k++) begin
            v = (k < cap_data.size()) ? cap_data[k] : 8'h00;
            for (int b = 7; b >= 0; b--) bits.push_back(v[b]);
        end
        for (int r = 0; r < nraw; r++) begin
            for (int b = 0; b < 5; b++) c = {c[3:0], bits[r*10+b]};
            nh = ungcr(c);
            for (int b = 0; b < 5; b++) c = {c[3:0], bits[r*10+5+b]};
            nl = ungcr(c);
            if (nh[4] || nl[4]) dec_bad++;
            dec_q.push_back({nh[3:0], nl[3:0]});
        end
    endtask

    task automatic build_model(input logic [5:0] trk, input logic [4:0] sec,
                               input logic [7:0] i1, input logic [7:0] i2);
        logic [7:0] x;
        exp_q.delete();
        repeat (SYNC_LEN) exp_q.push_back(8'hFF);
        raw_q.delete();
        raw_q.push_back(8'h08);
        raw_q.push_back({3'b000, sec} ^ {2'b00, trk} ^ i2 ^ i1);
        raw_q.push_back({3'b000, sec});
        raw_q.push_back({2'b00, trk});
        raw_q.push_back(i2);
        raw_q.push_back(i1);
        raw_q.push_back(8'h0F);
        raw_q.push_back(8'h0F);
        gcr_pack();
        repeat (GAP1_LEN) exp_q.push_back(8'h55);
        repeat (SYNC_LEN) exp_q.push_back(8'hFF);
        raw_q.delete();
        raw_q.push_back(8'h07);
        x = 8'h00;
        for (int i = 0; i < 256; i++) begin
            raw_q.push_back(mem[i]);
            x ^= mem[i];
        end
        raw_q.push_back(x);
        raw_q.push_back(8'h00);
        raw_q.push_back(8'h00);
        gcr_pack();
        repeat (GAP2_LEN) exp_q.push_back(8'h55);
    endtask

    task automatic check_stream(input string tag, input logic [12:0] base);
        int md, ma;
        md = 0;
        ma = 0;
        check({tag, "_count"}, 64'(cap_data.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < cap_data.size(); i++) begin
            if (cap_data[i] !== exp_q[i]) md++;
            if (cap_addr[i] !== 13'(base + 13'(i))) ma++;
        end
        check({tag, "_data_mismatches"}, 64'(md), 64'd0);
        check({tag, "_addr_mismatches"}, 64'(ma), 64'd0);
    endtask

    task automatic start_sector(input logic [12:0] base, input logic [5:0] trk, input logic [4:0] sec,
                                input logic [7:0] i1, input logic [7:0] i2);
        cap_data.delete();
        cap_addr.delete();
        bus.base_addr = base;
        bus.track     = trk;
        bus.sector    = sec;
        bus.id1       = i1;
        bus.id2       = i2;
        ce            = 1'b1;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start     = 1'b0;
        bus.base_addr = ~base;
        bus.track     = ~trk;
        bus.sector    = ~sec;
        bus.id1       = ~i1;
        bus.id2       = ~i2;
    endtask

    task automatic run_sector(input logic [12:0] base, input logic [5:0] trk, input logic [4:0] sec,
                              input logic [7:0] i1, input logic [7:0] i2, input bit rand_ce,
                              input bit poke_start, output bit ok, output int ndone);
        int d0;
        d0 = done_cnt;
        ok = 1'b0;
        start_sector(base, trk, sec, i1, i2);
        for (int i = 0; i < 20000; i++) begin
            if (done_cnt > d0) begin
                ok = 1'b1;
                break;
            end
            ce = rand_ce ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.start = (poke_start && (i == 300 || i == 301)) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        ce = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        ndone = done_cnt - d0;
    endtask

    initial begin
        bit ok;
        int nd, mm, n;
        logic [63:0] v;
        logic [7:0]  x;
        logic [5:0]  trk_b;
        logic [4:0]  sec_b;
        logic [7:0]  id1_b, id2_b;

        bus.start = 1'b0;
        bus.track = '0;
        bus.sector = '0;
        bus.id1 = 8'h00;
        bus.id2 = 8'h00;
        bus.base_addr = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        // Reset state
        #3 reset_n = 1'b0;
        #10;
        check("rst_out_we", 64'(bus.out_we), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_out_addr", 64'(bus.out_addr), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_data_addr", 64'(bus.data_addr), 64'd0);
        check("rst_out_len", 64'(bus.out_len), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // All-zero sector, known header
        run_sector(13'h0100, 6'd1, 5'd0, 8'h41, 8'h42, 1'b0, 1'b0, ok, nd);
        check("a_done_seen", 64'(ok), 64'd1);
        check("a_done_once", 64'(nd), 64'd1);
        check("a_out_len", 64'(bus.out_len), 64'd362);
        check("a_busy_after", 64'(bus.busy), 64'd0);
        build_model(6'd1, 5'd0, 8'h41, 8'h42);
        check_stream("a", 13'h0100);
        v = '0;
        for (int i = 0; i < 5; i++) v = {v[55:0], cap_data[i]};
        check("a_header_sync", v, 64'hFF_FFFF_FFFF);
        gcr_unpack(HDR_OFF, 8);
        v = '0;
        for (int i = 0; i < 8; i++) v = {v[55:0], dec_q[i]};
        check("a_header_raw", v, 64'h0802_0001_4241_0F0F);
        check("a_header_codes", 64'(dec_bad), 64'd0);
        v = '0;
        for (int i = 0; i < 5; i++) v = {v[55:0], cap_data[DATA_OFF+i]};
        check("a_data_grp0", v, 64'h55_D4A5_294A);
        v = '0;
        for (int i = 5; i < 10; i++) v = {v[55:0], cap_data[DATA_OFF+i]};
        check("a_data_grp1", v, 64'h52_94A5_294A);
        gcr_unpack(DATA_OFF, 260);
        check("a_dchk_zero", 64'(dec_q[257]), 64'h00);

        // Random sector across the address wrap
        for (int i = 0; i < 256; i++) begin
            mem[i]   = 8'($urandom);
            mem_b[i] = mem[i];
        end
        trk_b = 6'($urandom_range(1, 35));
        sec_b = 5'($urandom_range(0, 20));
        id1_b = 8'($urandom);
        id2_b = 8'($urandom);
        ce_viol = 0;
        run_sector(13'h1FF0, trk_b, sec_b, id1_b, id2_b, 1'b0, 1'b0, ok, nd);
        check("b_done_seen", 64'(ok), 64'd1);
        check("b_done_once", 64'(nd), 64'd1);
        check("b_out_len", 64'(bus.out_len), 64'd362);
        build_model(trk_b, sec_b, id1_b, id2_b);
        check_stream("b", 13'h1FF0);
        check("b_last_addr", 64'((cap_addr.size() == 362) ? cap_addr[361] : 13'h0), 64'h0159);
        gcr_unpack(DATA_OFF, 260);
        mm = 0;
        x = 8'h00;
        for (int r = 0; r < 260; r++) begin
            if (r >= 1 && r <= 256) x ^= mem[r-1];
            if (r == 0 && dec_q[r] !== 8'h07) mm++;
            if (r >= 1 && r <= 256 && dec_q[r] !== mem[r-1]) mm++;
            if (r == 257 && dec_q[r] !== x) mm++;
            if (r >= 258 && dec_q[r] !== 8'h00) mm++;
        end
        check("b_data_roundtrip", 64'(mm + dec_bad), 64'd0);
        ref_q = cap_data;

        // Checksum patterns
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        run_sector(13'h0000, 6'd18, 5'd3, 8'h30, 8'h31, 1'b0, 1'b0, ok, nd);
        check("c1_done_seen", 64'(ok), 64'd1);
        build_model(6'd18, 5'd3, 8'h30, 8'h31);
        check_stream("c1", 13'h0000);
        gcr_unpack(DATA_OFF, 260);
        check("c1_dchk", 64'(dec_q[257]), 64'h00);
        for (int i = 0; i < 256; i++) mem[i] = (i == 0) ? 8'h00 : 8'hFF;
        run_sector(13'h0800, 6'd35, 5'd16, 8'hA5, 8'h5A, 1'b0, 1'b0, ok, nd);
        check("c2_done_seen", 64'(ok), 64'd1);
        gcr_unpack(DATA_OFF, 260);
        check("c2_dchk", 64'(dec_q[257]), 64'hFF);
        check("c2_codes", 64'(dec_bad), 64'd0);

        // Random ce, redundant start while busy: stream must equal the ce=1 run
        for (int i = 0; i < 256; i++) mem[i] = mem_b[i];
        ce_viol = 0;
        run_sector(13'h1FF0, trk_b, sec_b, id1_b, id2_b, 1'b1, 1'b1, ok, nd);
        check("d_done_seen", 64'(ok), 64'd1);
        check("d_done_once", 64'(nd), 64'd1);
        check("d_out_len", 64'(bus.out_len), 64'd362);
        check("d_we_without_ce", 64'(ce_viol), 64'd0);
        mm = 0;
        for (int i = 0; i < ref_q.size() && i < cap_data.size(); i++) begin
            if (cap_data[i] !== ref_q[i]) mm++;
        end
        check("d_vs_ce1_len", 64'(cap_data.size()), 64'(ref_q.size()));
        check("d_vs_ce1_bytes", 64'(mm), 64'd0);
        build_model(trk_b, sec_b, id1_b, id2_b);
        check_stream("d", 13'h1FF0);

        // Reset mid-DATA, then a clean sector
        start_sector(13'h0400, 6'd7, 5'd9, 8'h11, 8'h22);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (cap_data.size() >= 120) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("e_reached_data", 64'(ok), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("e_busy_in_reset", 64'(bus.busy), 64'd0);
        check("e_we_in_reset", 64'(bus.out_we), 64'd0);
        n = cap_data.size();
        repeat (5) @(posedge clk);
        #1;
        check("e_no_writes_in_reset", 64'(cap_data.size()), 64'(n));
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_sector(13'h0400, 6'd7, 5'd9, 8'h11, 8'h22, 1'b0, 1'b0, ok, nd);
        check("e_done_seen", 64'(ok), 64'd1);
        check("e_done_once", 64'(nd), 64'd1);
        check("e_out_len", 64'(bus.out_len), 64'd362);
        build_model(6'd7, 5'd9, 8'h11, 8'h22);
        check_stream("e", 13'h0400);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
